// File: rtl/npc_pkg.sv
// Shared types and helpers for the next-PC / branch prediction unit.
package npc_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Per-entry BTB state; tag and target live in width-parameterised arrays.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } btb_meta_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        if (up)
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        else
            return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped BTB storage: combinational lookup read, plus a read/write
// pair at the EX-side update index (read feeds the update policy).
module npc_btb
    import npc_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BTB_DEPTH = 16,
    localparam int IDX_W    = $clog2(BTB_DEPTH),
    localparam int TAG_W    = PC_W - IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_lk_idx,
    output btb_meta_t        o_lk_meta,
    output logic [TAG_W-1:0] o_lk_tag,
    output logic [PC_W-1:0]  o_lk_target,
    input  logic [IDX_W-1:0] i_up_idx,
    output btb_meta_t        o_up_meta,
    output logic [TAG_W-1:0] o_up_tag,
    output logic [PC_W-1:0]  o_up_target,
    input  logic             i_wr_en,
    input  btb_meta_t        i_wr_meta,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [PC_W-1:0]  i_wr_target
);

    btb_meta_t        r_meta   [BTB_DEPTH];
    logic [TAG_W-1:0] r_tag    [BTB_DEPTH];
    logic [PC_W-1:0]  r_target [BTB_DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++)
                r_meta[i] <= '{valid: 1'b0, ctr: CTR_SNT};
        end else if (i_wr_en) begin
            r_meta[i_up_idx] <= i_wr_meta;
        end
    end

    // Tag/target are qualified by valid, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_up_idx]    <= i_wr_tag;
            r_target[i_up_idx] <= i_wr_target;
        end
    end

    assign o_lk_meta   = r_meta[i_lk_idx];
    assign o_lk_tag    = r_tag[i_lk_idx];
    assign o_lk_target = r_target[i_lk_idx];
    assign o_up_meta   = r_meta[i_up_idx];
    assign o_up_tag    = r_tag[i_up_idx];
    assign o_up_target = r_target[i_up_idx];

endmodule

// File: rtl/npc_bp.sv
// Next-PC unit: fetch PC register, BTB-based prediction, EX-stage branch
// resolution, mispredict redirect and BTB update policy.
module npc_bp
    import npc_pkg::*;
#(
    parameter int           PC_W      = 32,
    parameter int           BTB_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    output logic [PC_W-1:0] o_pc,
    output logic            o_pred_taken,
    output logic [PC_W-1:0] o_pred_npc,
    input  logic            i_ex_valid,
    input  logic [PC_W-1:0] i_ex_pc,
    input  logic [31:0]     i_ex_a,
    input  logic            i_ex_eq,
    input  logic            i_ex_j,
    input  logic            i_ex_jr,
    input  logic            i_ex_jal,
    input  logic            i_ex_beq,
    input  logic            i_ex_bne,
    input  logic            i_ex_blez,
    input  logic [PC_W-1:0] i_ex_index,
    input  logic [PC_W-1:0] i_ex_offset,
    input  logic            i_ex_pred_taken,
    input  logic [PC_W-1:0] i_ex_pred_npc,
    output logic            o_mispredict,
    output logic [PC_W-1:0] o_correct_npc
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W;

    logic [PC_W-1:0]  r_pc;
    btb_meta_t        w_lk_meta, w_up_meta, w_wr_meta;
    logic [TAG_W-1:0] w_lk_tag, w_up_tag;
    logic [PC_W-1:0]  w_lk_target, w_up_target, w_wr_target;
    logic             w_lk_hit, w_up_hit, w_wr_en;
    logic             w_cond, w_taken, w_xfer;
    logic [PC_W-1:0]  w_seq_npc, w_br_npc, w_correct_npc;
    logic             w_unused;

    // The mispredict check compares full next-PCs, so the piped taken bit is redundant.
    assign w_unused = i_ex_pred_taken;

    npc_btb #(.PC_W(PC_W), .BTB_DEPTH(BTB_DEPTH)) u_btb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lk_idx    (r_pc[IDX_W-1:0]),
        .o_lk_meta   (w_lk_meta),
        .o_lk_tag    (w_lk_tag),
        .o_lk_target (w_lk_target),
        .i_up_idx    (i_ex_pc[IDX_W-1:0]),
        .o_up_meta   (w_up_meta),
        .o_up_tag    (w_up_tag),
        .o_up_target (w_up_target),
        .i_wr_en     (w_wr_en),
        .i_wr_meta   (w_wr_meta),
        .i_wr_tag    (i_ex_pc[PC_W-1:IDX_W]),
        .i_wr_target (w_wr_target)
    );

    assign w_lk_hit     = w_lk_meta.valid & (w_lk_tag == r_pc[PC_W-1:IDX_W]);
    assign o_pred_taken = w_lk_hit & w_lk_meta.ctr[1];
    assign o_pred_npc   = o_pred_taken ? w_lk_target : r_pc + PC_W'(1);
    assign o_pc         = r_pc;

    assign w_cond    = (i_ex_eq & i_ex_beq) | (~i_ex_eq & i_ex_bne)
                     | ((i_ex_eq | i_ex_a[31]) & i_ex_blez);
    assign w_xfer    = i_ex_j | i_ex_jr | i_ex_jal | i_ex_beq | i_ex_bne | i_ex_blez;
    assign w_taken   = i_ex_j | i_ex_jal | i_ex_jr | w_cond;
    assign w_seq_npc = i_ex_pc + PC_W'(1);
    assign w_br_npc  = w_seq_npc + i_ex_offset;

    always_comb begin
        if (i_ex_jr)
            w_correct_npc = i_ex_a[PC_W-1:0];
        else if (i_ex_j | i_ex_jal)
            w_correct_npc = i_ex_index;
        else if (w_cond)
            w_correct_npc = w_br_npc;
        else
            w_correct_npc = w_seq_npc;
    end

    assign o_correct_npc = w_correct_npc;
    assign o_mispredict  = i_ex_valid & (i_ex_pred_npc != w_correct_npc);

    // A hit on a non-control instruction means a stale alias: drop the entry.
    assign w_up_hit = w_up_meta.valid & (w_up_tag == i_ex_pc[PC_W-1:IDX_W]);

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_meta   = w_up_meta;
        w_wr_target = w_up_target;
        if (i_ex_valid) begin
            if (w_xfer && w_up_hit) begin
                w_wr_en       = 1'b1;
                w_wr_meta.ctr = ctr_step(w_up_meta.ctr, w_taken);
                if (w_taken)
                    w_wr_target = w_correct_npc;
            end else if (w_xfer && w_taken) begin
                w_wr_en     = 1'b1;
                w_wr_meta   = '{valid: 1'b1, ctr: CTR_WT};
                w_wr_target = w_correct_npc;
            end else if (!w_xfer && w_up_hit) begin
                w_wr_en         = 1'b1;
                w_wr_meta.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pc <= RESET_PC;
        else if (o_mispredict)
            r_pc <= w_correct_npc;
        else if (!i_stall)
            r_pc <= o_pred_npc;
    end

endmodule

// File: tb/tb_npc_bp.sv
// Randomised + directed bench for npc_bp against a behavioural BTB/PC model.
module tb_npc_bp;

    localparam int          PC_W  = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] DEP   = 32'd16;

    logic        clk = 1'b0;
    logic        rst_n, stall;
    logic [31:0] pc, pred_npc, correct_npc;
    logic        pred_taken, mispredict;
    logic        ex_valid, ex_eq, ex_j, ex_jr, ex_jal, ex_beq, ex_bne, ex_blez, ex_pred_taken;
    logic [31:0] ex_pc, ex_a, ex_index, ex_offset, ex_pred_npc;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];

    npc_bp #(.PC_W(PC_W), .BTB_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .o_pc(pc), .o_pred_taken(pred_taken), .o_pred_npc(pred_npc),
        .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_ex_a(ex_a), .i_ex_eq(ex_eq),
        .i_ex_j(ex_j), .i_ex_jr(ex_jr), .i_ex_jal(ex_jal),
        .i_ex_beq(ex_beq), .i_ex_bne(ex_bne), .i_ex_blez(ex_blez),
        .i_ex_index(ex_index), .i_ex_offset(ex_offset),
        .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_npc(ex_pred_npc),
        .o_mispredict(mispredict), .o_correct_npc(correct_npc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_pc = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0; m_ctr[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
        end
    endfunction

    function automatic logic [31:0] m_resolve(output bit tk);
        bit c;
        c  = (ex_beq && ex_eq) || (ex_bne && !ex_eq) || (ex_blez && (ex_eq || $signed(ex_a) < 0));
        tk = ex_j || ex_jal || ex_jr || c;
        if (ex_jr) return ex_a;
        if (ex_j || ex_jal) return ex_index;
        if (c) return ex_pc + 32'd1 + ex_offset;
        return ex_pc + 32'd1;
    endfunction

    task automatic clr_ex();
        ex_valid = 0; ex_pc = '0; ex_a = '0; ex_eq = 0;
        ex_j = 0; ex_jr = 0; ex_jal = 0; ex_beq = 0; ex_bne = 0; ex_blez = 0;
        ex_index = '0; ex_offset = '0; ex_pred_taken = 0; ex_pred_npc = '0;
    endtask

    // Checks the current cycle against the model, advances one clock, and
    // leaves time just past the next falling edge.
    task automatic step();
        logic [31:0] pnpc, cnpc, npc;
        bit ptk, tk, xfer, hit, ehit, misp;
        int idx, ei;
        #1;
        idx  = int'(m_pc % DEP);
        hit  = m_valid[idx] && (m_tag[idx] == m_pc / DEP);
        ptk  = hit && (m_ctr[idx] >= 2);
        pnpc = ptk ? m_tgt[idx] : m_pc + 32'd1;
        cnpc = m_resolve(tk);
        xfer = ex_j || ex_jr || ex_jal || ex_beq || ex_bne || ex_blez;
        misp = ex_valid && (ex_pred_npc != cnpc);
        chk("pc", pc, m_pc);
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, ptk});
        chk("pred_npc", pred_npc, pnpc);
        chk("correct_npc", correct_npc, cnpc);
        chk("mispredict", {31'b0, mispredict}, {31'b0, misp});
        npc = misp ? cnpc : (stall ? m_pc : pnpc);
        @(posedge clk);
        m_pc = npc;
        ei   = int'(ex_pc % DEP);
        ehit = m_valid[ei] && (m_tag[ei] == ex_pc / DEP);
        if (ex_valid) begin
            if (xfer) begin
                if (ehit) begin
                    if (tk) begin
                        m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
                        m_tgt[ei] = cnpc;
                    end else begin
                        m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
                    end
                end else if (tk) begin
                    m_valid[ei] = 1'b1; m_tag[ei] = ex_pc / DEP; m_tgt[ei] = cnpc; m_ctr[ei] = 2;
                end
            end else if (ehit) begin
                m_valid[ei] = 1'b0;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic set_br(input logic [31:0] p, input bit eq, input logic [31:0] off,
                          input logic [31:0] pred);
        clr_ex(); stall = 0;
        ex_valid = 1; ex_pc = p; ex_beq = 1; ex_eq = eq; ex_offset = off;
        ex_pred_npc = pred; ex_pred_taken = (pred != p + 32'd1);
    endtask

    task automatic set_jr(input logic [31:0] p, input logic [31:0] a, input logic [31:0] pred);
        clr_ex(); stall = 0;
        ex_valid = 1; ex_pc = p; ex_jr = 1; ex_a = a; ex_pred_npc = pred;
    endtask

    // Redirect fetch to t via a mispredicted non-control instruction at t-1.
    task automatic goto(input logic [31:0] t);
        clr_ex(); stall = 0;
        ex_valid = 1; ex_pc = t - 32'd1; ex_pred_npc = t + 32'd7;
        step();
    endtask

    task automatic rand_cycle();
        bit dummy;
        clr_ex();
        stall    = ($urandom_range(0, 4) == 0);
        ex_valid = ($urandom_range(0, 7) != 0);
        ex_pc    = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 47));
        case ($urandom_range(0, 7))
            1: ex_j = 1;
            2: ex_jr = 1;
            3: ex_jal = 1;
            4: ex_beq = 1;
            5: ex_bne = 1;
            6: ex_blez = 1;
            default: ;
        endcase
        ex_eq = 1'($urandom_range(0, 1));
        ex_a  = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) ex_a[31] = 1'b1;
        ex_index  = 32'($urandom_range(0, 63));
        ex_offset = 32'($urandom_range(0, 15)) - 32'd8;
        case ($urandom_range(0, 2))
            0: ex_pred_npc = ex_pc + 32'd1;
            1: ex_pred_npc = m_resolve(dummy);
            default: ex_pred_npc = 32'($urandom_range(0, 63));
        endcase
        ex_pred_taken = (ex_pred_npc != ex_pc + 32'd1);
        step();
    endtask

    initial begin
        clr_ex(); stall = 0; rst_n = 0; m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, 32'd0);
        chk("rst_pred_npc", pred_npc, 32'd1);
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        rst_n = 1;

        for (int k = 0; k < 4; k++) begin
            chk("count_pc", pc, 32'(k));
            clr_ex(); stall = 0; step();
        end

        // Cold taken beq at 8 -> 5, then predicted next time.
        set_br(32'd8, 1, -32'd4, 32'd9);
        #1;
        chk("beq_misp", {31'b0, mispredict}, 32'd1);
        chk("beq_cnpc", correct_npc, 32'd5);
        step();
        chk("beq_redirect", pc, 32'd5);
        repeat (3) begin clr_ex(); step(); end
        chk("beq_pc8", pc, 32'd8);
        chk("beq_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("beq_pred_npc", pred_npc, 32'd5);

        // Hysteresis: T (ST), N (WT, still taken), N (WNT).
        set_br(32'd8, 1, -32'd4, 32'd5); step();
        set_br(32'd8, 0, -32'd4, 32'd5);
        #1;
        chk("hyst_misp", {31'b0, mispredict}, 32'd1);
        chk("hyst_cnpc", correct_npc, 32'd9);
        step();
        goto(32'd8);
        chk("hyst_wt_taken", {31'b0, pred_taken}, 32'd1);
        chk("hyst_wt_npc", pred_npc, 32'd5);
        set_br(32'd8, 0, -32'd4, 32'd9); step();
        goto(32'd8);
        chk("hyst_wnt_taken", {31'b0, pred_taken}, 32'd0);
        chk("hyst_wnt_npc", pred_npc, 32'd9);

        // jr target change.
        set_jr(32'd20, 32'd100, 32'd21); step();
        set_jr(32'd20, 32'd200, 32'd100);
        #1;
        chk("jr_misp", {31'b0, mispredict}, 32'd1);
        chk("jr_cnpc", correct_npc, 32'd200);
        step();
        goto(32'd20);
        chk("jr_btb_tgt", pred_npc, 32'd200);

        // blez on negative rs.
        clr_ex(); ex_valid = 1; ex_pc = 32'd10; ex_blez = 1; ex_a = 32'h8000_0000;
        ex_offset = 32'd3; ex_pred_npc = 32'd11;
        #1;
        chk("blez_cnpc", correct_npc, 32'd14);
        step();
        chk("blez_pc", pc, 32'd14);

        // Stall vs mispredict, then stall alone.
        clr_ex(); stall = 1; ex_valid = 1; ex_pc = 32'd50; ex_pred_npc = 32'd0;
        step();
        chk("stall_misp_pc", pc, 32'd51);
        clr_ex(); stall = 1; step();
        chk("stall_hold_pc", pc, 32'd51);

        // Wrap-around on not-taken branch at the top of the address space.
        set_br(32'hFFFF_FFFF, 0, 32'd5, 32'd7);
        #1;
        chk("wrap_cnpc", correct_npc, 32'd0);
        step();
        chk("wrap_pc", pc, 32'd0);

        for (int k = 0; k < 1500; k++) begin
            if (k == 700) begin
                #2 rst_n = 0;
                #1;
                chk("mid_rst_pc", pc, 32'd0);
                chk("mid_rst_pred_npc", pred_npc, 32'd1);
                chk("mid_rst_pred_taken", {31'b0, pred_taken}, 32'd0);
                m_reset();
                @(negedge clk);
                #1 rst_n = 1;
            end
            rand_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
